// File: rtl/pulse_gen_if.sv
// rtl/pulse_gen_if.sv - burst request and pulse status bundle for pulse_gen
interface pulse_gen_if #(
    parameter int CNT_WIDTH = 8,
    parameter int LEN_WIDTH = 8
);
    logic                 i_start;
    logic                 i_abort;
    logic [CNT_WIDTH-1:0] i_num;
    logic [LEN_WIDTH-1:0] i_high_len;
    logic [LEN_WIDTH-1:0] i_low_len;
    logic                 o_pulse;
    logic                 o_busy;
    logic                 o_done;
    logic [CNT_WIDTH-1:0] o_sent;

    modport master (
        output i_start, i_abort, i_num, i_high_len, i_low_len,
        input  o_pulse, o_busy, o_done, o_sent
    );

    modport slave (
        input  i_start, i_abort, i_num, i_high_len, i_low_len,
        output o_pulse, o_busy, o_done, o_sent
    );
endinterface

// File: rtl/pulse_gen.sv
// rtl/pulse_gen.sv - pulse burst generator sized for a 16-clock qualified pulse counter
module pulse_gen #(
    parameter int CNT_WIDTH = 8,
    parameter int LEN_WIDTH = 8
) (
    input  logic         i_clk,
    input  logic         i_rst,
    pulse_gen_if.slave   bus
);
    typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_DONE} state_t;

    // The downstream counter needs 16 clocks of high to qualify a pulse and
    // at least 2 low clocks to see the gap between pulses.
    localparam logic [LEN_WIDTH:0] MIN_HIGH = (LEN_WIDTH+1)'(16);
    localparam logic [LEN_WIDTH:0] MIN_LOW  = (LEN_WIDTH+1)'(2);
    localparam logic [LEN_WIDTH:0] LEN_ONE  = (LEN_WIDTH+1)'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t               state_q, state_d;
    logic [LEN_WIDTH:0]   timer_q, timer_d;
    logic [LEN_WIDTH:0]   hc_q, hc_d;
    logic [LEN_WIDTH:0]   lc_q, lc_d;
    logic [CNT_WIDTH-1:0] num_q, num_d;
    logic [CNT_WIDTH-1:0] sent_q, sent_d;

    logic [LEN_WIDTH:0]   high_ext, low_ext, hc_in, lc_in;

    assign high_ext = {1'b0, bus.i_high_len};
    assign low_ext  = {1'b0, bus.i_low_len};
    assign hc_in    = (high_ext < MIN_HIGH) ? MIN_HIGH : high_ext;
    assign lc_in    = (low_ext  < MIN_LOW)  ? MIN_LOW  : low_ext;

    // State, latched burst parameters, phase timer and sent counter
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            hc_q    <= '0;
            lc_q    <= '0;
            num_q   <= '0;
            sent_q  <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            hc_q    <= hc_d;
            lc_q    <= lc_d;
            num_q   <= num_d;
            sent_q  <= sent_d;
        end
    end

    // Next state: timer counts down remaining cycles of the current phase
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        hc_d    = hc_q;
        lc_d    = lc_q;
        num_d   = num_q;
        sent_d  = sent_q;
        case (state_q)
            S_IDLE: begin
                if (bus.i_start && !bus.i_abort) begin
                    sent_d = '0;
                    num_d  = bus.i_num;
                    hc_d   = hc_in;
                    lc_d   = lc_in;
                    if (bus.i_num == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_HIGH;
                        timer_d = hc_in - LEN_ONE;
                    end
                end
            end
            S_HIGH: begin
                if (bus.i_abort) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end else if (timer_q == '0) begin
                    // Pulse is complete only once its full high time elapsed
                    sent_d  = sent_q + CNT_ONE;
                    state_d = S_LOW;
                    timer_d = lc_q - LEN_ONE;
                end else begin
                    timer_d = timer_q - LEN_ONE;
                end
            end
            S_LOW: begin
                if (bus.i_abort) begin
                    state_d = S_IDLE;
                    timer_d = '0;
                end else if (timer_q == '0) begin
                    if (sent_q < num_q) begin
                        state_d = S_HIGH;
                        timer_d = hc_q - LEN_ONE;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    timer_d = timer_q - LEN_ONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.o_pulse = (state_q == S_HIGH);
    assign bus.o_busy  = (state_q == S_HIGH) || (state_q == S_LOW);
    assign bus.o_done  = (state_q == S_DONE);
    assign bus.o_sent  = sent_q;
endmodule

// File: tb/tb_pulse_gen.sv
// tb/tb_pulse_gen.sv - directed self-checking bench for pulse_gen
module tb_pulse_gen;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    pulse_gen_if #(.CNT_WIDTH(8), .LEN_WIDTH(8)) bus ();

    pulse_gen #(.CNT_WIDTH(8), .LEN_WIDTH(8)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Called at a negedge with the DUT idle. Start is sampled at the next
    // posedge (cycle t); cycle c is observed at the c-th negedge after it.
    // stop_c > 0 injects abort (or reset when use_rst) during cycle stop_c.
    // extra_start_c > 0 raises i_start for one cycle during cycle extra_start_c.
    task automatic run_burst(input string tag, input int n, input int hl, input int ll,
                             input int stop_c, input bit use_rst, input int extra_start_c,
                             input int exp_sent, input int exp_qual);
        int hc, lc, per, done_c, last_c;
        int errs, dones, qual, run;
        bit ep, eb, ed;
        hc     = (hl < 16) ? 16 : hl;
        lc     = (ll < 2) ? 2 : ll;
        per    = hc + lc;
        done_c = 1 + n * per;
        last_c = (stop_c > 0) ? stop_c + 1 : done_c + 1;
        errs = 0; dones = 0; qual = 0; run = 0;
        bus.i_num      = 8'(n);
        bus.i_high_len = 8'(hl);
        bus.i_low_len  = 8'(ll);
        bus.i_start    = 1'b1;
        for (int c = 1; c <= last_c; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (stop_c > 0 && c > stop_c) begin
                ep = 0; eb = 0; ed = 0;
            end else if (c < done_c) begin
                ep = (((c - 1) % per) < hc);
                eb = 1; ed = 0;
            end else if (c == done_c) begin
                ep = 0; eb = 0; ed = 1;
            end else begin
                ep = 0; eb = 0; ed = 0;
            end
            if (bus.o_pulse !== ep || bus.o_busy !== eb || bus.o_done !== ed) begin
                if (errs == 0)
                    $display("  %s first trace deviation at cycle %0d: pulse=%0b busy=%0b done=%0b want %0b %0b %0b",
                             tag, c, bus.o_pulse, bus.o_busy, bus.o_done, ep, eb, ed);
                errs++;
            end
            if (bus.o_done === 1'b1) dones++;
            if (bus.o_pulse === 1'b1) begin
                run++;
                if (run == 16) qual++;
            end else begin
                run = 0;
            end
            bus.i_start = (c == extra_start_c && c != last_c);
            bus.i_abort = (c == stop_c && !use_rst);
            rst         = (c == stop_c && use_rst);
        end
        check_eq({tag, "_trace_errs"}, errs, 0);
        check_eq({tag, "_done_count"}, dones, (stop_c > 0) ? 0 : 1);
        check_eq({tag, "_qualified"}, qual, exp_qual);
        check_eq({tag, "_sent"}, int'(bus.o_sent), exp_sent);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst            = 1'b1;
        bus.i_start    = 1'b0;
        bus.i_abort    = 1'b0;
        bus.i_num      = '0;
        bus.i_high_len = '0;
        bus.i_low_len  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_pulse", int'(bus.o_pulse), 0);
        check_eq("rst_busy",  int'(bus.o_busy), 0);
        check_eq("rst_done",  int'(bus.o_done), 0);
        check_eq("rst_sent",  int'(bus.o_sent), 0);
        rst = 1'b0;
        @(negedge clk);

        // 3 pulses, high 20, low 4: done at t+73
        run_burst("b3x20x4", 3, 20, 4, 0, 0, 0, 3, 3);
        // short lengths clamped to 16/2: done at t+37
        run_burst("b2clamp", 2, 3, 0, 0, 0, 0, 2, 2);
        // zero pulses: done at t+1, never busy
        run_burst("b0", 0, 20, 4, 0, 0, 0, 0, 0);
        // abort during third high (cycles 37..52) at cycle 40
        run_burst("babort", 5, 16, 2, 40, 0, 0, 2, 2);
        // immediate restart after abort; start during DONE (cycle 19) ignored
        run_burst("brestart", 1, 16, 2, 0, 0, 19, 1, 1);
        // reset during second low (cycles 41..48) at cycle 44
        run_burst("breset", 4, 16, 8, 44, 1, 0, 0, 2);
        rst = 1'b0;
        // second start while busy is ignored
        run_burst("bbusystart", 2, 20, 4, 0, 0, 10, 2, 2);
        // full-scale count
        run_burst("b255", 255, 16, 2, 0, 0, 0, 255, 255);

        // abort and start together in IDLE: abort wins
        bus.i_num   = 8'd3;
        bus.i_start = 1'b1;
        bus.i_abort = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.i_start = 1'b0;
        bus.i_abort = 1'b0;
        check_eq("abort_start_busy",  int'(bus.o_busy), 0);
        check_eq("abort_start_pulse", int'(bus.o_pulse), 0);
        @(posedge clk);
        @(negedge clk);
        check_eq("abort_start_idle", int'(bus.o_busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pulse_gen.md
PULSE_GEN -- requirements
Module: pulse_gen

Interface
REQ-001 Parameter CNT_WIDTH, default 8: width of pulse-count request and sent-count output.
REQ-002 Parameter LEN_WIDTH, default 8: width of high/low length inputs; SHALL be >= 5.
REQ-003 i_clk  input  1  single clock; all logic on rising edge.
REQ-004 i_rst  input  1  reset, synchronous, active-high.
REQ-005 i_start  input  1  request a burst; sampled only in IDLE.
REQ-006 i_abort  input  1  terminate burst; sampled in every state.
REQ-007 i_num  input  CNT_WIDTH  number of pulses in the burst.
REQ-008 i_high_len  input  LEN_WIDTH  requested pulse high time, in clocks.
REQ-009 i_low_len  input  LEN_WIDTH  requested gap low time, in clocks.
REQ-010 o_pulse  output  1  generated pulse line, registered.
REQ-011 o_busy  output  1  burst in progress.
REQ-012 o_done  output  1  one-cycle strobe on normal burst completion.
REQ-013 o_sent  output  CNT_WIDTH  pulses fully emitted in current/last burst.

Function
REQ-014 Purpose: emit pulse bursts that a qualified-pulse counter (16-clock high qualification, one count per high period) counts exactly once per pulse.
REQ-015 Effective high time Hc SHALL be max(i_high_len, 16); effective low time Lc SHALL be max(i_low_len, 2).
REQ-016 i_num, Hc and Lc SHALL be latched on the accepting start cycle; input changes during a burst have no effect.
REQ-017 FSM states: IDLE, HIGH, LOW, DONE.
REQ-018 IDLE: o_pulse=0, o_busy=0. i_start=1, i_abort=0, i_num!=0 -> clear o_sent, go HIGH.
REQ-019 IDLE with i_start=1, i_num=0 -> o_sent cleared, go DONE (o_done strobe, no pulse).
REQ-020 HIGH: o_pulse=1, o_busy=1 for exactly Hc cycles; on last HIGH cycle o_sent increments (visible next cycle); go LOW.
REQ-021 LOW: o_pulse=0, o_busy=1 for exactly Lc cycles; then go HIGH if o_sent < latched num, else go DONE.
REQ-022 DONE: o_done=1, o_busy=0, o_pulse=0 for one cycle; then IDLE. i_start in DONE ignored.
REQ-023 Latency: start sampled at cycle t -> o_pulse=1 from t+1 to t+Hc; pulse k (k>=1) high starts at t+1+(k-1)(Hc+Lc); o_done at t+1+N(Hc+Lc).
REQ-024 i_start while busy (HIGH/LOW) SHALL be ignored; no restart, no queueing.
REQ-025 i_abort=1 in HIGH or LOW -> next cycle IDLE, o_pulse=0, o_busy=0, no o_done; o_sent holds its value (partial pulse not counted).
REQ-026 i_abort and i_start together in IDLE -> abort wins, start ignored.
REQ-027 Length timer SHALL be LEN_WIDTH+1 bits wide so Hc/Lc up to 2^LEN_WIDTH-1 never wrap; o_sent never exceeds latched num (no wrap).
REQ-028 i_num = 2^CNT_WIDTH-1 SHALL be supported with o_sent reaching exactly that value.

Reset
REQ-029 i_rst=1 at any rising edge, including mid-burst -> next cycle: state IDLE, o_pulse=0, o_busy=0, o_done=0, o_sent=0, latched values and timers 0.
REQ-030 i_rst SHALL take priority over i_start and i_abort.

Verification
REQ-031 i_num=3, i_high_len=20, i_low_len=4, start at t -> o_pulse high t+1..t+20, t+25..t+44, t+49..t+68; o_done at t+73; o_sent=3.
REQ-032 i_num=2, i_high_len=3, i_low_len=0 -> Hc=16, Lc=2: high t+1..t+16, t+19..t+34; o_done at t+37; downstream counter reads 2.
REQ-033 i_num=0 start -> no o_pulse, o_done at t+1, o_sent=0, o_busy never 1.
REQ-034 i_num=5, i_high_len=16, i_low_len=2, abort during 3rd HIGH -> o_pulse 0 next cycle, o_sent=2, no o_done; re-start next cycle accepted.
REQ-035 Reset asserted mid-LOW of burst i_num=4 -> all outputs 0 next cycle; second i_start during burst ignored (checked separately: pulse count unchanged).
REQ-036 i_num=255, i_high_len=16, i_low_len=2 -> exactly 255 pulses, o_sent=255, o_done once.
